// File: rtl/mem_arbiter.sv
// Single-port line-memory arbiter for I-fill, D-fill and D victim write-back.
// One memory command is outstanding at a time; each requester gets a completion pulse.
module mem_arbiter #(
  parameter int LINE_BITS = 128,
  parameter int ADDR_BITS = 10,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Ic_mem_req,
  input  logic [ADDR_BITS-1:0] Ic_mem_addr,
  output logic [LINE_BITS-1:0] F_mem_inst,
  output logic                 F_mem_valid,
  input  logic                 Dc_mem_req,
  input  logic [ADDR_BITS-1:0] Dc_mem_addr,
  output logic [LINE_BITS-1:0] MEM_data_line,
  output logic                 MEM_mem_valid,
  input  logic                 Dc_wb_we,
  input  logic [ADDR_BITS-1:0] Dc_wb_addr,
  input  logic [LINE_BITS-1:0] Dc_wb_wline,
  output logic                 Dc_wb_ack,
  output logic                 Arb_mem_req,
  output logic                 Arb_mem_we,
  output logic [ADDR_BITS-1:0] Arb_mem_addr,
  output logic [LINE_BITS-1:0] Arb_mem_wline,
  input  logic [LINE_BITS-1:0] Mem_rline,
  input  logic                 Mem_valid,
  output logic [1:0]           Arb_grant,
  output logic                 Arb_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_WB   = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [LINE_BITS-1:0] wline_q, wline_d;
  logic                 last_d_q, last_d_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [LINE_BITS-1:0] iline_q, iline_d;
  logic [LINE_BITS-1:0] dline_q, dline_d;
  logic [1:0]           mask_q, mask_d;

  logic                 wb_ok, i_ok, d_ok;
  logic [1:0]           grant;

  // mask_q is non-zero only in the first IDLE cycle after RESP
  assign wb_ok = Dc_wb_we   && (mask_q != OWN_WB);
  assign i_ok  = Ic_mem_req && (mask_q != OWN_I);
  assign d_ok  = Dc_mem_req && (mask_q != OWN_D);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wline_d  = wline_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    iline_d  = iline_q;
    dline_d  = dline_q;
    mask_d   = OWN_NONE;
    grant    = OWN_NONE;

    case (state_q)
      IDLE: begin
        if (wb_ok) begin
          grant = OWN_WB;
        end else if (i_ok && d_ok) begin
          grant = last_d_q ? OWN_I : OWN_D;
        end else if (i_ok) begin
          grant = OWN_I;
        end else if (d_ok) begin
          grant = OWN_D;
        end
        if (grant != OWN_NONE) begin
          owner_d = grant;
          we_d    = (grant == OWN_WB);
          wline_d = (grant == OWN_WB) ? Dc_wb_wline : '0;
          case (grant)
            OWN_WB:  addr_d = Dc_wb_addr;
            OWN_I:   addr_d = Ic_mem_addr;
            default: addr_d = Dc_mem_addr;
          endcase
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (Mem_valid) begin
          if (owner_q == OWN_I) iline_d = Mem_rline;
          if (owner_q == OWN_D) dline_d = Mem_rline;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // watchdog: complete the stuck transaction with a zero line
            err_d = 1'b1;
            if (owner_q == OWN_I) iline_d = '0;
            if (owner_q == OWN_D) dline_d = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        mask_d = owner_q;
        if (owner_q == OWN_I) last_d_d = 1'b0;
        if (owner_q == OWN_D) last_d_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wline_q  <= '0;
      last_d_q <= 1'b1;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      iline_q  <= '0;
      dline_q  <= '0;
      mask_q   <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wline_q  <= wline_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      iline_q  <= iline_d;
      dline_q  <= dline_d;
      mask_q   <= mask_d;
    end
  end

  assign Arb_mem_req   = (state_q == ISSUE);
  assign Arb_mem_we    = Arb_mem_req && we_q;
  assign Arb_mem_addr  = Arb_mem_req ? addr_q : '0;
  assign Arb_mem_wline = Arb_mem_req ? wline_q : '0;
  assign Arb_grant     = (state_q == IDLE) ? OWN_NONE : owner_q;
  assign F_mem_valid   = (state_q == RESP) && (owner_q == OWN_I);
  assign MEM_mem_valid = (state_q == RESP) && (owner_q == OWN_D);
  assign Dc_wb_ack     = (state_q == RESP) && (owner_q == OWN_WB);
  assign F_mem_inst    = iline_q;
  assign MEM_data_line = dline_q;
  assign Arb_err       = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port backing-memory arbiter between the I-cache line-fill path, the D-cache line-fill path and the D-cache victim write-back path. It sits between `icache`/`dcache` and a single-ported line memory. It serialises their requests into one outstanding memory transaction at a time. Each requester receives a one-cycle valid or ack pulse when its transaction completes.

## Interface
Parameters:
- `LINE_BITS`, 128, cache line width
- `ADDR_BITS`, 10, line-index width
- `TIMEOUT`, 64, maximum WAIT cycles before the watchdog fires (≥2)

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-low reset.
- `Ic_mem_req` in 1: I-side line read request, level, held until `F_mem_valid`.
- `Ic_mem_addr` in ADDR_BITS: I-side line index.
- `F_mem_inst` out LINE_BITS: I-side read line.
- `F_mem_valid` out 1: I-side completion pulse.
- `Dc_mem_req` in 1: D-side line read request, level, held until `MEM_mem_valid`.
- `Dc_mem_addr` in ADDR_BITS: D-side read line index.
- `MEM_data_line` out LINE_BITS: D-side read line.
- `MEM_mem_valid` out 1: D-side read completion pulse.
- `Dc_wb_we` in 1: write-back request, level, held until `Dc_wb_ack`.
- `Dc_wb_addr` in ADDR_BITS: write-back line index.
- `Dc_wb_wline` in LINE_BITS: write-back data.
- `Dc_wb_ack` out 1: write-back completion pulse.
- `Arb_mem_req` out 1: one-cycle command pulse to memory.
- `Arb_mem_we` out 1: command is a write.
- `Arb_mem_addr` out ADDR_BITS: command line index.
- `Arb_mem_wline` out LINE_BITS: write data.
- `Mem_rline` in LINE_BITS: memory read data.
- `Mem_valid` in 1: memory completion pulse. Pulses for both reads and writes.
- `Arb_grant` out 2: current owner. 0 none, 1 I, 2 D-read, 3 WB.
- `Arb_err` out 1: sticky watchdog flag.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - Evaluate requests. Priority: WB > (D-read vs I round-robin).
  - Round-robin bit `last_d`: when both reads are pending, the side not served last wins. `last_d` resets to 1, so I wins the first tie.
  - On a grant, latch owner, addr, we and wline, then go to ISSUE. With no request, stay in IDLE.
- ISSUE:
  - `Arb_mem_req`=1 for exactly one cycle, driven from the latched command.
  - Clear the watchdog counter and go to WAIT.
- WAIT:
  - On `Mem_valid`: latch `Mem_rline` (reads only) and go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT: set `Arb_err`, latch a zero line, go to RESP.
- RESP:
  - Pulse the owner's completion output for one cycle: `F_mem_valid`, `MEM_mem_valid` or `Dc_wb_ack`.
  - Line data is held on `F_mem_inst`/`MEM_data_line` until the next response on that side.
  - Update `last_d` for read owners only. Go to IDLE.
- Post-RESP mask: in the first IDLE cycle after RESP, the just-served requester is masked. This allows its request to drop one cycle late.
- A WB pending in the same IDLE cycle as a D-read to the same index goes first. This gives dirty-victim-before-refill ordering.
- `Mem_valid` outside WAIT is ignored. Requester inputs outside IDLE are ignored.
- `Arb_err` clears only on reset.

## Timing
- Reset (`rst`=0 at a rising edge), from any state, including mid-transaction:
  - State returns to IDLE, `last_d`=1, counter=0.
  - All outputs read 0: valids, ack, `Arb_mem_*`, lines, `Arb_grant`, `Arb_err`.
  - A late `Mem_valid` from the aborted transaction is dropped.
- `Arb_grant` is nonzero from ISSUE through RESP inclusive.
- Latency, counted from the first IDLE cycle in which a request is seen (cycle 0):
  - ISSUE at cycle 1.
  - A memory with latency L pulses `Mem_valid` at cycle 1+L.
  - RESP (completion pulse) at cycle 2+L.
  - IDLE at cycle 3+L.
- Back-to-back throughput: one transaction per L+3 cycles.
- Watchdog: with no `Mem_valid`, RESP at cycle 2+TIMEOUT with `Arb_err`=1 from that cycle on.
- Simultaneous WB + D-read + I-read at cycle 0: order is WB, then I (`last_d`=1 after reset), then D.

## Test plan
- Single I-read, L=3:
  - Stimulus: `Ic_mem_req`=1, addr 0x005, memory returns 0xA5…A5.
  - Required: `Arb_mem_req` at cycle 1 with we=0, addr 0x005. `F_mem_valid` pulse at cycle 5 with `F_mem_inst`=0xA5…A5. No `MEM_mem_valid`.
- All three requests asserted together:
  - Required: grants WB(3), I(1), D(2) in that order.
  - Required: `Dc_wb_ack`, `F_mem_valid`, `MEM_mem_valid` pulses spaced 6 cycles apart (L=3).
  - Required: `Arb_mem_we`=1 only on the first command.
- I and D read held continuously for 4 grants:
  - Required: strict alternation I, D, I, D.
  - Required: the requester held high after a serve is not re-granted in the masked IDLE cycle.
- Watchdog with TIMEOUT=8:
  - Stimulus: D-read with memory never responding.
  - Required: `MEM_mem_valid` at cycle 10, `MEM_data_line`=0, `Arb_err`=1 and sticky.
  - Required: next request still served normally.
- Reset mid-WAIT:
  - Stimulus: `rst`=0 for one cycle during WAIT, then memory pulses `Mem_valid` two cycles later.
  - Required: all outputs 0 after reset, no completion pulse, next I-read served with standard timing.
- Write-back data path:
  - Stimulus: `Dc_wb_wline`=0x0123…CDEF at addr 0x3FF.
  - Required: `Arb_mem_wline`/`Arb_mem_addr` match during ISSUE. `Dc_wb_ack` only after `Mem_valid`.
